// File: rtl/psum_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psum_accumulator_pkg
// Brief    : Shared sizing constants and types for the partial-sum accumulator.
// Revision : 1.0
// ============================================================================
package psum_accumulator_pkg;

    localparam int SYS_COLS     = 3;
    localparam int P_BITWIDTH   = 16;
    localparam int ACC_BITWIDTH = 32;
    localparam int OUT_BITWIDTH = 8;
    localparam int ACC_DEPTH    = 16;
    localparam int SHIFT_BITS   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } acc_state_t;

    typedef logic signed [ACC_BITWIDTH-1:0] acc_t;

endpackage
`default_nettype wire

// File: rtl/psum_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : psum_accumulator_if
// Brief    : Input partial-sum stream and output activation stream handshakes.
// Revision : 1.0
// ============================================================================
interface psum_accumulator_if #(
    parameter int SYS_COLS     = psum_accumulator_pkg::SYS_COLS,
    parameter int P_BITWIDTH   = psum_accumulator_pkg::P_BITWIDTH,
    parameter int OUT_BITWIDTH = psum_accumulator_pkg::OUT_BITWIDTH
);

    logic                                     in_valid;
    logic                                     in_ready;
    logic [SYS_COLS-1:0][P_BITWIDTH-1:0]      in_data;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [SYS_COLS-1:0][OUT_BITWIDTH-1:0]    out_data;

    // master = array side feeding sums plus the activation consumer
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface
`default_nettype wire

// File: rtl/psum_accumulator_requant_lane.sv
`default_nettype none
// ============================================================================
// Module   : requant_lane
// Brief    : One column of rounded arithmetic right shift, ReLU and clip.
// Revision : 1.0
// ============================================================================
module requant_lane
    import psum_accumulator_pkg::*;
#(
    parameter int ACC_W   = psum_accumulator_pkg::ACC_BITWIDTH,
    parameter int OUT_W   = psum_accumulator_pkg::OUT_BITWIDTH,
    parameter int SHIFT_W = psum_accumulator_pkg::SHIFT_BITS
) (
    input  logic signed [ACC_W-1:0]   i_acc,
    input  logic        [SHIFT_W-1:0] i_shift,
    output logic        [OUT_W-1:0]   o_q
);

    localparam logic signed [ACC_W:0] c_max = (ACC_W+1)'((1 << OUT_W) - 1);

    logic signed [ACC_W:0] w_round;
    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_y;

    // one extra bit so the rounding add cannot wrap a near-full accumulator
    assign w_round = (i_shift == '0) ? '0 : ((ACC_W+1)'(1) << (i_shift - 1'b1));
    assign w_sum   = {i_acc[ACC_W-1], i_acc} + w_round;
    assign w_y     = w_sum >>> i_shift;

    assign o_q = w_y[ACC_W]    ? '0 :
                 (w_y > c_max) ? {OUT_W{1'b1}} :
                                 w_y[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : psum_accumulator
// Brief    : K-tile partial-sum accumulation buffer with requantised row drain.
// Revision : 1.0
// ============================================================================
module psum_accumulator #(
    parameter int SYS_COLS     = psum_accumulator_pkg::SYS_COLS,
    parameter int P_BITWIDTH   = psum_accumulator_pkg::P_BITWIDTH,
    parameter int ACC_BITWIDTH = psum_accumulator_pkg::ACC_BITWIDTH,
    parameter int OUT_BITWIDTH = psum_accumulator_pkg::OUT_BITWIDTH,
    parameter int DEPTH        = psum_accumulator_pkg::ACC_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(DEPTH+1)-1:0]   cfg_rows,
    input  logic [7:0]                   cfg_ktiles,
    input  logic [4:0]                   cfg_shift,
    psum_accumulator_if.slave            bus,
    output logic                         done,
    output logic                         err_overrun
);

    import psum_accumulator_pkg::*;

    localparam int c_rows_w = $clog2(DEPTH+1);
    localparam int c_ptr_w  = $clog2(DEPTH);

    acc_state_t                               r_state;
    acc_state_t                               w_next_state;
    logic [c_rows_w-1:0]                      r_rows;
    logic [7:0]                               r_ktiles;
    logic [4:0]                               r_shift;
    logic [c_ptr_w-1:0]                       r_wr_ptr;
    logic [c_ptr_w-1:0]                       r_rd_ptr;
    logic [7:0]                               r_pass;
    logic [SYS_COLS-1:0][ACC_BITWIDTH-1:0]    r_buf [DEPTH];
    logic                                     r_out_valid;
    logic [SYS_COLS-1:0][OUT_BITWIDTH-1:0]    r_out_data;
    logic                                     r_err;

    logic                                     w_start_ok;
    logic                                     w_wr_en;
    logic                                     w_wr_last_row;
    logic                                     w_last_pass;
    logic                                     w_accum_done;
    logic                                     w_rd_last;
    logic                                     w_drain_done;
    logic [c_ptr_w-1:0]                       w_rd_idx;
    logic [SYS_COLS-1:0][ACC_BITWIDTH-1:0]    w_wr_row;
    logic [SYS_COLS-1:0][ACC_BITWIDTH-1:0]    w_rd_row;
    logic [SYS_COLS-1:0][OUT_BITWIDTH-1:0]    w_q_row;
    logic                                     w_in_ready;
    logic                                     w_done;

    assign w_start_ok    = (r_state == IDLE) && start;
    assign w_wr_en       = (r_state == ACCUM) && bus.in_valid;
    assign w_wr_last_row = c_rows_w'(r_wr_ptr) == (r_rows - c_rows_w'(1));
    assign w_last_pass   = r_pass == (r_ktiles - 8'd1);
    assign w_accum_done  = w_wr_en && w_wr_last_row && w_last_pass;
    assign w_rd_last     = c_rows_w'(r_rd_ptr) == (r_rows - c_rows_w'(1));
    assign w_drain_done  = (r_state == DRAIN) && r_out_valid && bus.out_ready && w_rd_last;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)        w_next_state = ACCUM;
            ACCUM:   if (w_accum_done) w_next_state = DRAIN;
            DRAIN:   if (w_drain_done) w_next_state = DONE;
            DONE:                      w_next_state = IDLE;
            default:                   w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ACCUM:   w_in_ready = 1'b1;
            DONE:    w_done     = 1'b1;
            default: ;
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign done          = w_done;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign err_overrun   = r_err;

    // ------------------------------------------------------ configuration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rows   <= '0;
            r_ktiles <= '0;
            r_shift  <= '0;
        end else if (w_start_ok) begin
            r_rows   <= cfg_rows;
            r_ktiles <= cfg_ktiles;
            r_shift  <= cfg_shift;
        end
    end

    // ------------------------------------------------- accumulation write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_pass   <= '0;
        end else if (w_start_ok) begin
            r_wr_ptr <= '0;
            r_pass   <= '0;
        end else if (w_wr_en) begin
            if (w_wr_last_row) begin
                r_wr_ptr <= '0;
                r_pass   <= r_pass + 8'd1;
            end else begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
        end else if (w_wr_en) begin
            r_buf[r_wr_ptr] <= w_wr_row;
        end
    end

    // First row of a drain reads rd_ptr; afterwards the next row is prefetched.
    assign w_rd_idx = r_out_valid ? (r_rd_ptr + 1'b1) : r_rd_ptr;
    assign w_rd_row = r_buf[w_rd_idx];

    for (genvar c = 0; c < SYS_COLS; c++) begin : g_col
        logic signed [ACC_BITWIDTH-1:0] w_ext;
        logic signed [ACC_BITWIDTH-1:0] w_old;
        logic signed [ACC_BITWIDTH:0]   w_sum;

        assign w_ext = {{(ACC_BITWIDTH-P_BITWIDTH){bus.in_data[c][P_BITWIDTH-1]}}, bus.in_data[c]};
        assign w_old = r_buf[r_wr_ptr][c];
        assign w_sum = {w_old[ACC_BITWIDTH-1], w_old} + {w_ext[ACC_BITWIDTH-1], w_ext};

        // top two sum bits differing means the signed add left the accumulator range
        assign w_wr_row[c] = (r_pass == 8'd0) ? w_ext :
                             (w_sum[ACC_BITWIDTH] != w_sum[ACC_BITWIDTH-1]) ?
                                 (w_sum[ACC_BITWIDTH] ? {1'b1, {(ACC_BITWIDTH-1){1'b0}}}
                                                      : {1'b0, {(ACC_BITWIDTH-1){1'b1}}}) :
                             w_sum[ACC_BITWIDTH-1:0];

        requant_lane #(
            .ACC_W   (ACC_BITWIDTH),
            .OUT_W   (OUT_BITWIDTH),
            .SHIFT_W (5)
        ) u_lane (
            .i_acc   (w_rd_row[c]),
            .i_shift (r_shift),
            .o_q     (w_q_row[c])
        );
    end

    // ---------------------------------------------------- drain register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (r_state == DRAIN) begin
            if (!r_out_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_q_row;
            end else if (bus.out_ready) begin
                if (w_rd_last) begin
                    r_out_valid <= 1'b0;
                end else begin
                    r_rd_ptr   <= r_rd_ptr + 1'b1;
                    r_out_data <= w_q_row;
                end
            end
        end else begin
            r_rd_ptr <= '0;
        end
    end

    // ------------------------------------------------------------ overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= bus.in_valid;
        end else if (bus.in_valid && (r_state != ACCUM)) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_accumulator
// Brief    : Scoreboard bench for psum_accumulator with directed job vectors.
// Revision : 1.0
// ============================================================================
module tb_psum_accumulator;

    import psum_accumulator_pkg::*;

    typedef logic [2:0][7:0] orow_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [4:0] cfg_rows = '0;
    logic [7:0] cfg_ktiles = '0;
    logic [4:0] cfg_shift = '0;
    logic       done;
    logic       err_overrun;

    logic       start_s = 1'b0;
    logic [4:0] cfg_rows_s = '0;
    logic [7:0] cfg_ktiles_s = '0;
    logic [4:0] cfg_shift_s = '0;
    logic       done_s;
    logic       err_s;

    int    n_vec = 0;
    int    n_err = 0;
    orow_t exp_q[$];
    orow_t sat_q[$];

    psum_accumulator_if bus ();
    psum_accumulator_if sbus ();

    psum_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_rows    (cfg_rows),
        .cfg_ktiles  (cfg_ktiles),
        .cfg_shift   (cfg_shift),
        .bus         (bus),
        .done        (done),
        .err_overrun (err_overrun)
    );

    // narrow accumulator so saturation is reachable within a short pass count
    psum_accumulator #(.ACC_BITWIDTH(20)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .start       (start_s),
        .cfg_rows    (cfg_rows_s),
        .cfg_ktiles  (cfg_ktiles_s),
        .cfg_shift   (cfg_shift_s),
        .bus         (sbus),
        .done        (done_s),
        .err_overrun (err_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic orow_t mkrow(input int a, input int b, input int c);
        orow_t r;
        r[0] = 8'(a);
        r[1] = 8'(b);
        r[2] = 8'(c);
        return r;
    endfunction

    always @(negedge clk) begin
        orow_t e;
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_row: got %h expected none", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                check("row", bus.out_data, e);
            end
        end
    end

    always @(negedge clk) begin
        orow_t e;
        if (rst && sbus.out_valid && sbus.out_ready) begin
            if (sat_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_sat_row: got %h expected none", sbus.out_data);
            end else begin
                e = sat_q.pop_front();
                check("sat_row", sbus.out_data, e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int rows, input int kt, input int sh, input bit with_valid);
        cfg_rows   = 5'(rows);
        cfg_ktiles = 8'(kt);
        cfg_shift  = 5'(sh);
        start      = 1'b1;
        if (with_valid) begin
            bus.in_valid   = 1'b1;
            bus.in_data[0] = 16'd99;
            bus.in_data[1] = 16'd99;
            bus.in_data[2] = 16'd99;
        end
        cyc();
        start        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input int a, input int b, input int c);
        bus.in_valid   = 1'b1;
        bus.in_data[0] = 16'(a);
        bus.in_data[1] = 16'(b);
        bus.in_data[2] = 16'(c);
        cyc();
        bus.in_valid   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done"}, 64'(seen), 64'd1);
        if (seen) begin
            @(negedge clk);
            check({name, "_done_pulse"}, 64'(done), 64'd0);
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        sbus.in_valid  = 1'b0;
        sbus.in_data   = '0;
        sbus.out_ready = 1'b1;

        repeat (3) cyc();
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_overrun), 64'd0);
        rst = 1'b1;
        cyc();

        // single pass, basic requant
        exp_q.push_back(mkrow(5, 0, 255));
        exp_q.push_back(mkrow(0, 7, 255));
        start_job(2, 1, 0, 1'b0);
        check("t1_in_ready", 64'(bus.in_ready), 64'd1);
        send(5, -3, 300);
        send(0, 7, 255);
        wait_done("t1");

        // multi-pass with rounding; start+in_valid flags overrun but writes nothing
        exp_q.push_back(mkrow(8, 0, 5));
        start_job(1, 3, 2, 1'b1);
        check("t2_err_start_valid", 64'(err_overrun), 64'd1);
        repeat (3) send(10, -10, 6);
        check("t2_acc0", 64'(dut.r_buf[0][0]), 64'h0000_001E);
        check("t2_acc1", 64'(dut.r_buf[0][1]), 64'hFFFF_FFE2);
        check("t2_acc2", 64'(dut.r_buf[0][2]), 64'h0000_0012);
        wait_done("t2");

        // backpressure on row 1
        exp_q.push_back(mkrow(1, 2, 3));
        exp_q.push_back(mkrow(4, 5, 6));
        exp_q.push_back(mkrow(7, 8, 9));
        start_job(3, 1, 0, 1'b0);
        check("t3_err_cleared", 64'(err_overrun), 64'd0);
        send(1, 2, 3);
        send(4, 5, 6);
        send(7, 8, 9);
        cyc();
        cyc();
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall_valid", 64'(bus.out_valid), 64'd1);
            check("t3_stall_data", 64'(bus.out_data), 64'(mkrow(4, 5, 6)));
            cyc();
        end
        bus.out_ready = 1'b1;
        wait_done("t3");

        // overrun during drain
        exp_q.push_back(mkrow(10, 20, 30));
        exp_q.push_back(mkrow(40, 50, 60));
        start_job(2, 1, 0, 1'b0);
        send(10, 20, 30);
        send(40, 50, 60);
        send(99, 99, 99);
        check("t4_err_set", 64'(err_overrun), 64'd1);
        wait_done("t4");
        check("t4_err_sticky", 64'(err_overrun), 64'd1);

        // reset mid-accumulation
        start_job(2, 2, 0, 1'b0);
        check("t5_err_cleared", 64'(err_overrun), 64'd0);
        send(50, 60, 70);
        #2;
        rst = 1'b0;
        #1;
        check("t5_in_ready", 64'(bus.in_ready), 64'd0);
        check("t5_out_valid", 64'(bus.out_valid), 64'd0);
        check("t5_out_data", 64'(bus.out_data), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_err", 64'(err_overrun), 64'd0);
        check("t5_state", 64'(dut.r_state), 64'(IDLE));
        cyc();
        rst = 1'b1;
        cyc();
        exp_q.push_back(mkrow(1, 2, 3));
        exp_q.push_back(mkrow(4, 5, 6));
        start_job(2, 1, 0, 1'b0);
        send(1, 2, 3);
        send(4, 5, 6);
        wait_done("t5");

        // saturation: 200 passes drive a 20-bit accumulator to both rails
        sat_q.push_back(mkrow(1, 1, 0));
        cfg_rows_s   = 5'd1;
        cfg_ktiles_s = 8'd200;
        cfg_shift_s  = 5'd19;
        start_s      = 1'b1;
        cyc();
        start_s = 1'b0;
        for (int p = 0; p < 200; p++) begin
            sbus.in_valid   = 1'b1;
            sbus.in_data[0] = 16'sd32767;
            sbus.in_data[1] = 16'sd32767;
            sbus.in_data[2] = 16'h8000;
            cyc();
        end
        sbus.in_valid = 1'b0;
        check("t6_acc_max", 64'(u_sat.r_buf[0][0]), 64'h7_FFFF);
        check("t6_acc_min", 64'(u_sat.r_buf[0][2]), 64'h8_0000);
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (done_s) seen = 1'b1;
        end
        check("t6_done", 64'(seen), 64'd1);
        check("t6_drained", 64'(sat_q.size()), 64'd0);
        check("t6_err", 64'(err_s), 64'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the systolic-array top. Consumes the per-column partial-sum vector it emits each time its ready/valid strobe fires.
- Accumulates partial sums across K-dimension tiles in a small row buffer.
- After the last tile, drains each row through requantisation (rounded arithmetic right shift, ReLU, unsigned clip) over a valid/ready output handshake.

Parameters:
- SYS_COLS, 3, columns per result vector (tracks Config::sys_cols)
- P_BITWIDTH, 16, signed width of each incoming partial sum (tracks Config::P_BITWIDTH)
- ACC_BITWIDTH, 32, signed accumulator width per column
- OUT_BITWIDTH, 8, unsigned output activation width
- DEPTH, 16, rows held in the accumulation buffer

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches cfg_* and begins a job (honoured in IDLE only)
- cfg_rows  in  $clog2(DEPTH+1)  rows per tile, legal 1..DEPTH
- cfg_ktiles  in  8  K passes per job, legal 1..255
- cfg_shift  in  5  requant right-shift amount, 0..31
- in_valid  in  1  partial-sum vector valid (driven by the array's ready)
- in_data  in  [SYS_COLS-1:0][P_BITWIDTH-1:0]  signed partial sums
- in_ready  out  1  high only in ACCUM
- out_valid  out  1  output row valid
- out_ready  in  1  consumer accepts the row
- out_data  out  [SYS_COLS-1:0][OUT_BITWIDTH-1:0]  requantised row
- done  out  1  one-cycle pulse after the last row is accepted
- err_overrun  out  1  sticky; set when in_valid=1 while in_ready=0; cleared by start

Behaviour:
- Reset, asynchronous on the falling edge of rst:
  - state IDLE, buffer, pointers and counters cleared.
  - Outputs: in_ready, out_valid, out_data, done and err_overrun all 0.
- States and transitions:
  - IDLE -> ACCUM on start; the cfg_* values are latched at that edge.
  - ACCUM -> DRAIN after the final write of pass cfg_ktiles-1.
  - DRAIN -> DONE after row cfg_rows-1 is accepted.
  - DONE -> IDLE unconditionally.
  - done is high for the single DONE cycle.
- ACCUM, on each in_valid cycle:
  - Write row wr_ptr, with in_data sign-extended to ACC_BITWIDTH.
  - Pass 0 overwrites the row. Later passes add to it, saturating at +/-(2^(ACC_BITWIDTH-1)) bounds.
  - wr_ptr wraps cfg_rows-1 -> 0 and increments the pass counter.
  - Cycles with in_valid=0 change nothing.
- DRAIN output register:
  - out_valid first rises the cycle after entering DRAIN.
  - Row r is presented as out_data. On out_valid && out_ready, row r+1 is presented on the next cycle with no bubble.
  - While stalled, out_data and out_valid are held stable.
- Requant, per column: y = (acc + (cfg_shift ? 1<<(cfg_shift-1) : 0)) >>> cfg_shift.
  - The rounding add is done at ACC_BITWIDTH+1 bits.
  - If y<0 the result is 0. If y>2^OUT_BITWIDTH-1 the result is 2^OUT_BITWIDTH-1. Otherwise the result is y.
- in_valid outside ACCUM is ignored (no write) and sets err_overrun.
- start outside IDLE is ignored.
- start together with in_valid in IDLE: start wins, and in_valid sets err_overrun (in_ready is still 0 that cycle).
- Reset mid-job aborts immediately and leaves no residue: the next job's pass 0 overwrites every row it uses.

Decomposition:
- Config package gains:
  - ACC_BITWIDTH, OUT_BITWIDTH and ACC_DEPTH constants.
  - typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} acc_state_t.
  - typedef logic signed [ACC_BITWIDTH-1:0] acc_t.
- One combinational sub-module, requant_lane: one column's round-shift-ReLU-clip, instantiated SYS_COLS times in a generate loop.

Test Plan:
- Single pass, basic requant:
  - Config: cfg_rows=2, cfg_ktiles=1, cfg_shift=0.
  - Stimulus: in_data {5,-3,300} then {0,7,255}.
  - Required: outputs {5,0,255} then {0,7,255}, then a single-cycle done.
- Multi-pass accumulation with rounding:
  - Config: cfg_rows=1, cfg_ktiles=3, cfg_shift=2.
  - Stimulus: {10,-10,6} on each of the three passes.
  - Required: accumulators {30,-30,18}; output {8,0,5}.
- Backpressure:
  - Stimulus: drain 3 rows with out_ready held low 3 cycles on row 1.
  - Required: out_data frozen at row 1 with out_valid=1 throughout the stall; rows 0,1,2 appear in order with no duplicates.
- Overrun:
  - Stimulus: pulse in_valid with {99,99,99} during DRAIN.
  - Required: err_overrun=1 and drained values unchanged. The next start clears err_overrun.
- Reset mid-ACCUM:
  - Stimulus: drop rst after 1 of 2 rows; all outputs must be 0 and the state IDLE. Then run a new job with cfg_rows=2, cfg_ktiles=1 and inputs {1,2,3},{4,5,6}.
  - Required: outputs exactly {1,2,3},{4,5,6}, with no stale sums.
- Saturation:
  - Config: cfg_ktiles=200, cfg_shift=31.
  - Stimulus: in_data=32767 on all columns for every pass; drive the accumulator to the ceiling by forcing a preload of 2^31-100.
  - Required: the accumulator holds 2^31-1 and the output is 1.
